// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: drives the open-drain clock/data pins through
// output enables, frames one command byte per request and reports ACK, NACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYC  = 3360,
    parameter int FIRST_TO_CYC = 420000,
    parameter int PKT_TO_CYC   = 56000,
    parameter int FILTER_LEN   = 8
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rx_inhibit,
    output logic       done,
    output logic       error,
    output logic       err_timeout
);

    localparam int TW = $clog2(FIRST_TO_CYC + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    localparam logic [TW-1:0] TIMER_MAX  = '1;
    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] INH_DAT    = TW'(INHIBIT_CYC - 16);
    localparam logic [TW-1:0] FIRST_LAST = TW'(FIRST_TO_CYC - 1);
    localparam logic [TW-1:0] PKT_LAST   = TW'(PKT_TO_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, XFER, ACK, WAITREL, ERR
    } state_t;

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]    meta, sync, filt;
    logic [FW-1:0] cnt [2];
    logic          clk_prev;
    logic          fall;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            meta     <= '1;
            sync     <= '1;
            filt     <= '1;
            clk_prev <= 1'b1;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            meta     <= {ps2_dat_in, ps2_clk_in};
            sync     <= meta;
            clk_prev <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + FW'(1);
                end
            end
        end
    end

    assign fall = clk_prev & ~filt[0];

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [3:0]    bc, bc_d;
    logic [7:0]    sr, sr_d;
    logic          par, par_d;
    logic          drv, drv_d;
    logic          go_err, err_to, done_d;
    logic          clk_oe_d, dat_oe_d;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        timer_d = (timer == TIMER_MAX) ? timer : timer + TW'(1);
        bc_d    = bc;
        sr_d    = sr;
        par_d   = par;
        drv_d   = drv;
        done_d  = 1'b0;
        go_err  = 1'b0;
        err_to  = 1'b0;

        case (state)
            IDLE: begin
                timer_d = '0;
                if (tx_valid) begin
                    state_d = INHIBIT;
                    sr_d    = tx_data;
                    par_d   = ~^tx_data;
                    bc_d    = '0;
                end
            end
            INHIBIT: begin
                if (timer == INH_LAST) begin
                    state_d = REQ;
                    timer_d = '0;
                end
            end
            REQ: begin
                if (fall) begin
                    state_d = XFER;
                    timer_d = '0;
                    bc_d    = 4'd1;
                    drv_d   = ~sr[0];
                end else if (timer == FIRST_LAST) begin
                    go_err = 1'b1;
                    err_to = 1'b1;
                end
            end
            XFER: begin
                // The packet timer keeps running across bits; only REQ->XFER clears it.
                if (fall) begin
                    bc_d = bc + 4'd1;
                    if (bc <= 4'd7)       drv_d = ~sr[bc[2:0]];
                    else if (bc == 4'd8)  drv_d = ~par;
                    else if (bc == 4'd9)  drv_d = 1'b0;
                    else                  state_d = ACK;
                end else if (timer == PKT_LAST) begin
                    go_err = 1'b1;
                    err_to = 1'b1;
                end
            end
            ACK: begin
                if (filt[1]) begin
                    go_err = 1'b1;
                end else if (timer == PKT_LAST) begin
                    go_err = 1'b1;
                    err_to = 1'b1;
                end else begin
                    state_d = WAITREL;
                end
            end
            WAITREL: begin
                if (filt[0] && filt[1]) begin
                    state_d = IDLE;
                    timer_d = '0;
                    done_d  = 1'b1;
                end else if (timer == PKT_LAST) begin
                    go_err = 1'b1;
                    err_to = 1'b1;
                end
            end
            ERR: begin
                state_d = IDLE;
                timer_d = '0;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        if (go_err) begin
            state_d = ERR;
            timer_d = '0;
        end
    end

    // Pin enables are decoded from next-state values and registered, so the pins never glitch.
    always_comb begin
        clk_oe_d = (state_d == INHIBIT);
        case (state_d)
            INHIBIT: dat_oe_d = (timer_d >= INH_DAT);
            REQ:     dat_oe_d = 1'b1;
            XFER:    dat_oe_d = drv_d;
            default: dat_oe_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            bc          <= '0;
            sr          <= '0;
            par         <= 1'b0;
            drv         <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_dat_oe  <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state      <= state_d;
            timer      <= timer_d;
            bc         <= bc_d;
            sr         <= sr_d;
            par        <= par_d;
            drv        <= drv_d;
            ps2_clk_oe <= clk_oe_d;
            ps2_dat_oe <= dat_oe_d;
            done       <= done_d;
            error      <= go_err;
            if (go_err) err_timeout <= err_to;
        end
    end

    assign tx_ready   = (state == IDLE);
    assign rx_inhibit = (state != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model on wired-AND lines,
// a table of byte transfers plus hand-written timeout, reset and glitch sequences.
module tb_ps2_host_tx;

    localparam int INH   = 64;
    localparam int FTO   = 2000;
    localparam int PTO   = 1500;
    localparam int FLT   = 8;
    localparam int HALF  = 40;
    localparam int BUDGET = FTO + PTO;

    logic       clk28 = 1'b0;
    logic       rst;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, rx_inhibit, done, error, err_timeout;
    logic       dev_clk_low, dev_dat_low;

    wire clk_line = ~(ps2_clk_oe | dev_clk_low);
    wire dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .FIRST_TO_CYC(FTO),
        .PKT_TO_CYC  (PTO),
        .FILTER_LEN  (FLT)
    ) dut (
        .clk28      (clk28),
        .rst        (rst),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_inhibit (rx_inhibit),
        .done       (done),
        .error      (error),
        .err_timeout(err_timeout)
    );

    always #5 clk28 = ~clk28;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Event monitor: pulse counts and cycle stamps of REQ entry, XFER entry and errors.
    int   cyc = 0;
    int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int   req_cyc = 0, xfer_cyc = 0, err_cyc = 0;
    logic prev_clk_oe = 1'b0, prev_dat_oe = 1'b0, in_req = 1'b0;

    always @(posedge clk28) cyc <= cyc + 1;

    always @(negedge clk28) begin
        prev_clk_oe <= ps2_clk_oe;
        prev_dat_oe <= ps2_dat_oe;
        if (prev_clk_oe && !ps2_clk_oe) begin
            req_cyc <= cyc;
            in_req  <= 1'b1;
        end else if (in_req && prev_dat_oe && !ps2_dat_oe) begin
            xfer_cyc <= cyc;
            in_req   <= 1'b0;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (done && error) both_cnt <= both_cnt + 1;
    end

    // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Device model: waits for the request-to-send, then generates nclk clock pulses,
    // sampling data just before each rising edge; optional ACK and clock glitch.
    task automatic device(input int nclk, input bit ack, input int glitch,
                          output logic [10:0] frame, output bit ok);
        int w = 0;
        frame = '0;
        ok    = 1'b0;
        while (!(clk_line && !dat_line) && w < 500) begin
            @(negedge clk28);
            w++;
        end
        if (w >= 500) return;
        repeat (HALF) @(negedge clk28);
        frame[0] = dat_line;
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11 && ack) dev_dat_low = 1'b1;
            repeat (HALF) @(negedge clk28);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk28);
            if (k <= 10) frame[k] = dat_line;
            dev_clk_low = 1'b0;
            if (k == glitch) begin
                repeat (HALF / 2) @(negedge clk28);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk28);
                dev_clk_low = 1'b0;
            end
        end
        if (dev_dat_low) begin
            repeat (HALF) @(negedge clk28);
            dev_dat_low = 1'b0;
        end
        ok = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        int         nclk;
        int         glitch;
        bit         exp_done;
        bit         exp_to;
    } txn_t;

    task automatic check_idle(input string tag);
        check({tag, "_idle"}, {ps2_clk_oe, ps2_dat_oe, tx_ready, rx_inhibit}, 4'b0010);
    endtask

    task automatic run_txn(input txn_t t, output logic [10:0] frame);
        int  d0, e0, w;
        bit  ok;
        string tag;
        tag = $sformatf("txn_%02h", t.data);
        frame = '0;
        @(negedge clk28);
        tx_data  = t.data;
        tx_valid = 1'b1;
        @(negedge clk28);
        tx_valid = 1'b0;
        check({tag, "_busy"}, {tx_ready, rx_inhibit}, 2'b01);
        d0 = done_cnt;
        e0 = err_cnt;
        if (t.nclk > 0) begin
            device(t.nclk, t.ack, t.glitch, frame, ok);
            check({tag, "_req_seen"}, ok, 1);
        end
        w = 0;
        while (done_cnt == d0 && err_cnt == e0 && w < BUDGET) begin
            @(negedge clk28);
            w++;
        end
        check({tag, "_ended"}, w < BUDGET, 1);
        repeat (3) @(negedge clk28);
        check({tag, "_done_pulses"}, done_cnt - d0, t.exp_done ? 1 : 0);
        check({tag, "_err_pulses"}, err_cnt - e0, t.exp_done ? 0 : 1);
        if (!t.exp_done) check({tag, "_err_timeout"}, err_timeout, t.exp_to);
        if (t.nclk == 11) begin
            check({tag, "_frame"}, frame, ref_frame(t.data));
            check({tag, "_parity"}, frame[9], ref_frame(t.data) >> 9 & 1);
        end
        check_idle(tag);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t        tbl[$];
        txn_t        t;
        logic [10:0] frame;
        bit          ok;
        int          d0, e0, w;

        rst         = 1'b1;
        tx_valid    = 1'b0;
        tx_data     = '0;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clk28);
        check("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        check("reset_pulses", {done, error, err_timeout}, 3'b000);
        check("reset_ready", {tx_ready, rx_inhibit}, 2'b10);
        rst = 1'b0;
        repeat (2) @(negedge clk28);
        check_idle("post_reset");

        // Device never clocks: timeout measured from REQ entry.
        t = '{8'h55, 1'b0, 0, 0, 1'b0, 1'b1};
        run_txn(t, frame);
        check("first_to_latency", err_cyc - req_cyc, FTO);

        tbl.push_back('{8'hED, 1'b1, 11, 0, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b1, 11, 0, 1'b1, 1'b0});
        tbl.push_back('{8'hFF, 1'b1, 11, 0, 1'b1, 1'b0});
        tbl.push_back('{8'h01, 1'b1, 11, 0, 1'b1, 1'b0});
        tbl.push_back('{8'hAA, 1'b0, 11, 0, 1'b0, 1'b0});
        tbl.push_back('{8'h5A, 1'b1, 11, 4, 1'b1, 1'b0});
        for (int i = 0; i < 6; i++) begin
            t.data     = 8'($urandom_range(0, 255));
            t.ack      = 1'($urandom_range(0, 1));
            t.nclk     = 11;
            t.glitch   = (i == 2) ? 7 : 0;
            t.exp_done = t.ack;
            t.exp_to   = 1'b0;
            tbl.push_back(t);
        end
        foreach (tbl[i]) run_txn(tbl[i], frame);

        // Device stops after 5 clocks: timeout measured from XFER entry.
        t = '{8'hED, 1'b1, 5, 0, 1'b0, 1'b1};
        run_txn(t, frame);
        check("pkt_to_latency", err_cyc - xfer_cyc, PTO);

        // Asynchronous reset in the middle of the data bits.
        @(negedge clk28);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk28);
        tx_valid = 1'b0;
        device(4, 1'b0, 0, frame, ok);
        check("abort_req_seen", ok, 1);
        @(negedge clk28);
        check("abort_pre_dat", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
        d0 = done_cnt;
        e0 = err_cnt;
        #2 rst = 1'b1;
        #1 check("rst_async_release", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        repeat (3) @(negedge clk28);
        rst = 1'b0;
        repeat (20) @(negedge clk28);
        check("abort_no_pulses", {done_cnt - d0, err_cnt - e0}, 64'd0);
        check_idle("abort");
        t = '{8'hF4, 1'b1, 11, 0, 1'b1, 1'b0};
        run_txn(t, frame);

        // tx_valid held high: the next byte is taken in the cycle done is pulsed.
        @(negedge clk28);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        device(11, 1'b1, 0, frame, ok);
        check("b2b_first_frame", frame, ref_frame(8'h3C));
        w = 0;
        while (!done && w < BUDGET) begin
            @(negedge clk28);
            w++;
        end
        check("b2b_first_done", done, 1);
        check("b2b_ready_at_done", tx_ready, 1);
        tx_data = 8'hC3;
        @(negedge clk28);
        check("b2b_accepted", {tx_ready, rx_inhibit}, 2'b01);
        tx_valid = 1'b0;
        device(11, 1'b1, 0, frame, ok);
        check("b2b_second_frame", frame, ref_frame(8'hC3));
        w = 0;
        while (!done && w < BUDGET) begin
            @(negedge clk28);
            w++;
        end
        check("b2b_second_done", done, 1);
        repeat (2) @(negedge clk28);
        check_idle("b2b");

        check("done_error_exclusive", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
